// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: command, ALU-drive and response bundle for the ALU sequencer
//   cmd_*: command handshake and operands into the sequencer
//   alu_*: registered operands out to the ALU, with the combinational result back
//   rsp_*: result handshake out of the sequencer
//   slave: the sequencer's view; master: the environment's view
interface alu_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_sel;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_cin;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_sel;
  logic       alu_cin;
  logic [7:0] alu_out;
  logic       alu_ovf;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_overflow;
  modport slave (
    input  cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, alu_out, alu_ovf, rsp_ready,
    output cmd_ready, alu_a, alu_b, alu_sel, alu_cin, rsp_valid, rsp_data, rsp_overflow
  );
  modport master (
    output cmd_valid, cmd_sel, cmd_a, cmd_b, cmd_cin, alu_out, alu_ovf, rsp_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel, alu_cin, rsp_valid, rsp_data, rsp_overflow
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: sequences commands through the 8-bit ALU and runs shifts internally
//   clock, clear_n: rising-edge clock, synchronous active-low reset
//   bus: command in, ALU drive/return, response out (alu_sequencer_if.slave)
//   busy: high whenever the sequencer is not idle
module alu_sequencer #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clock,
  input  logic            clear_n,
  alu_sequencer_if.slave  bus,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_t;
  state_t     state, state_n;
  logic [3:0] cnt;
  logic [7:0] sh;
  logic [2:0] amt;
  logic       sticky;
  logic       accept;
  logic       shift_op;
  assign accept   = bus.cmd_valid && state == IDLE;
  assign shift_op = bus.cmd_sel[2] & bus.cmd_sel[1];
  always_ff @(posedge clock)
    if (!clear_n) state <= IDLE;
    else          state <= state_n;
  always_comb begin
    state_n       = state;
    bus.cmd_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        busy          = 1'b0;
        state_n       = accept ? (shift_op ? SHIFT : EXEC) : IDLE;
      end
      EXEC:  state_n = cnt == 4'd1 ? RESP : EXEC;
      SHIFT: state_n = amt == 3'd0 ? RESP : SHIFT;
      RESP: begin
        bus.rsp_valid = 1'b1;
        state_n       = bus.rsp_ready ? IDLE : RESP;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (!clear_n) begin
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.alu_sel      <= '0;
      bus.alu_cin      <= 1'b0;
      bus.rsp_data     <= '0;
      bus.rsp_overflow <= 1'b0;
      cnt              <= '0;
      sh               <= '0;
      amt              <= '0;
      sticky           <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_a   <= bus.cmd_a;
        bus.alu_b   <= bus.cmd_b;
        bus.alu_sel <= bus.cmd_sel;
        bus.alu_cin <= bus.cmd_cin;
        cnt         <= 4'(SETTLE_CYCLES);
        sh          <= bus.cmd_a;
        amt         <= bus.cmd_b[2:0];
        sticky      <= 1'b0;
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (cnt == 4'd1) begin
          bus.rsp_data     <= bus.alu_out;
          // only the adder drives a meaningful overflow; other selects leave it undefined
          bus.rsp_overflow <= bus.alu_sel == 3'd0 && bus.alu_ovf;
        end
      end
      // shifts never touch alu_out, so an unwired shift path cannot leak into the result
      if (state == SHIFT) begin
        if (amt == 3'd0) begin
          bus.rsp_data     <= sh;
          bus.rsp_overflow <= sticky;
        end else begin
          sh     <= bus.alu_sel[0] ? sh >> 1 : sh << 1;
          sticky <= sticky | (bus.alu_sel[0] ? sh[0] : sh[7]);
          amt    <= amt - 3'd1;
        end
      end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer (SETTLE_CYCLES 1 and 3)
module tb_alu_sequencer;
  logic       clock = 1'b0;
  logic       clear_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_sel = '0;
  logic [7:0] cmd_a = '0;
  logic [7:0] cmd_b = '0;
  logic       cmd_cin = 1'b0;
  logic       rsp_ready = 1'b0;
  logic       sel3 = 1'b0;
  logic       busy1, busy3;
  int         checks = 0;
  int         failures = 0;
  always #5 clock = ~clock;
  alu_sequencer_if i1();
  alu_sequencer_if i3();
  alu_sequencer #(.SETTLE_CYCLES(1)) dut1 (.clock(clock), .clear_n(clear_n), .bus(i1), .busy(busy1));
  alu_sequencer #(.SETTLE_CYCLES(3)) dut3 (.clock(clock), .clear_n(clear_n), .bus(i3), .busy(busy3));
  function automatic logic [8:0] alu_fn(input logic [7:0] a, b, input logic [2:0] sel, input logic cin);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    // non-add selects return a set overflow to prove the sequencer masks it
    case (sel)
      3'd0: return s;
      3'd1: return {1'b1, a - b};
      3'd2: return {1'b1, a & b};
      3'd3: return {1'b1, a | b};
      3'd4: return {1'b1, a ^ b};
      3'd5: return {1'b1, ~a};
      default: return {1'b1, 8'hA5};
    endcase
  endfunction
  assign {i1.alu_ovf, i1.alu_out} = alu_fn(i1.alu_a, i1.alu_b, i1.alu_sel, i1.alu_cin);
  assign {i3.alu_ovf, i3.alu_out} = alu_fn(i3.alu_a, i3.alu_b, i3.alu_sel, i3.alu_cin);
  assign i1.cmd_valid = cmd_valid & ~sel3;
  assign i3.cmd_valid = cmd_valid & sel3;
  assign i1.cmd_sel = cmd_sel;
  assign i3.cmd_sel = cmd_sel;
  assign i1.cmd_a = cmd_a;
  assign i3.cmd_a = cmd_a;
  assign i1.cmd_b = cmd_b;
  assign i3.cmd_b = cmd_b;
  assign i1.cmd_cin = cmd_cin;
  assign i3.cmd_cin = cmd_cin;
  assign i1.rsp_ready = rsp_ready;
  assign i3.rsp_ready = rsp_ready;
  logic       o_valid, o_ready, o_ovf, o_busy;
  logic [7:0] o_data;
  logic [2:0] o_sel;
  assign o_valid = sel3 ? i3.rsp_valid : i1.rsp_valid;
  assign o_ready = sel3 ? i3.cmd_ready : i1.cmd_ready;
  assign o_ovf   = sel3 ? i3.rsp_overflow : i1.rsp_overflow;
  assign o_busy  = sel3 ? busy3 : busy1;
  assign o_data  = sel3 ? i3.rsp_data : i1.rsp_data;
  assign o_sel   = sel3 ? i3.alu_sel : i1.alu_sel;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b, input logic cin);
    int n = 0;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    check("cmd_ready_wait", 32'(o_ready), 32'd1);
    cmd_sel = sel;
    cmd_a = a;
    cmd_b = b;
    cmd_cin = cin;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask
  task automatic run_op(input logic [2:0] sel, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input int lat, input logic [7:0] ed, input logic eo);
    send(sel, a, b, cin);
    for (int i = 1; i < lat; i++) begin
      check("early_valid", 32'(o_valid), 32'd0);
      check("ready_in_op", 32'(o_ready), 32'd0);
      check("sel_held", 32'(o_sel), 32'(sel));
      tick();
    end
    check("rsp_valid", 32'(o_valid), 32'd1);
    check("rsp_data", 32'(o_data), 32'(ed));
    check("rsp_overflow", 32'(o_ovf), 32'(eo));
    check("ready_in_resp", 32'(o_ready), 32'd0);
    rsp_ready = 1'b1;
    tick();
    check("valid_after_hs", 32'(o_valid), 32'd0);
    check("ready_after_hs", 32'(o_ready), 32'd1);
  endtask
  task automatic check_reset();
    check("rst_cmd_ready", 32'(i1.cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(i1.rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(i1.rsp_data), 32'd0);
    check("rst_rsp_ovf", 32'(i1.rsp_overflow), 32'd0);
    check("rst_alu_a", 32'(i1.alu_a), 32'd0);
    check("rst_alu_b", 32'(i1.alu_b), 32'd0);
    check("rst_alu_sel", 32'(i1.alu_sel), 32'd0);
    check("rst_alu_cin", 32'(i1.alu_cin), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
  endtask
  initial begin
    tick();
    tick();
    check_reset();
    clear_n = 1'b1;
    tick();
    send(3'd0, 8'hFF, 8'h00, 1'b1);
    check("add_accept_valid", 32'(i1.rsp_valid), 32'd0);
    check("add_busy", 32'(busy1), 32'd1);
    check("add_alu_a", 32'(i1.alu_a), 32'hFF);
    check("add_alu_cin", 32'(i1.alu_cin), 32'd1);
    check("add_alu_sel", 32'(i1.alu_sel), 32'd0);
    tick();
    check("add_valid", 32'(i1.rsp_valid), 32'd1);
    check("add_data", 32'(i1.rsp_data), 32'h00);
    check("add_ovf", 32'(i1.rsp_overflow), 32'd1);
    rsp_ready = 1'b1;
    tick();
    check("add_done", 32'(i1.rsp_valid), 32'd0);
    run_op(3'd1, 8'hFF, 8'hAA, 1'b1, 2, 8'h55, 1'b0);
    run_op(3'd2, 8'hA0, 8'hAA, 1'b0, 2, 8'hA0, 1'b0);
    run_op(3'd6, 8'h91, 8'hFB, 1'b0, 5, 8'h88, 1'b1);
    run_op(3'd7, 8'h0F, 8'h04, 1'b0, 6, 8'h00, 1'b1);
    run_op(3'd6, 8'h5A, 8'h00, 1'b0, 2, 8'h5A, 1'b0);
    rsp_ready = 1'b0;
    send(3'd3, 8'hA0, 8'h2C, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      check("bp_valid", 32'(i1.rsp_valid), 32'd1);
      check("bp_data", 32'(i1.rsp_data), 32'hAC);
      check("bp_ready", 32'(i1.cmd_ready), 32'd0);
      check("bp_busy", 32'(busy1), 32'd1);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(i1.rsp_valid), 32'd0);
    check("bp_release_busy", 32'(busy1), 32'd0);
    send(3'd7, 8'hFF, 8'h07, 1'b1);
    tick();
    tick();
    check("shift_busy", 32'(busy1), 32'd1);
    clear_n = 1'b0;
    tick();
    clear_n = 1'b1;
    check_reset();
    for (int i = 0; i < 10; i++) begin
      check("no_rsp_after_rst", 32'(i1.rsp_valid), 32'd0);
      tick();
    end
    run_op(3'd5, 8'h0F, 8'h00, 1'b0, 2, 8'hF0, 1'b0);
    sel3 = 1'b1;
    run_op(3'd4, 8'h23, 8'h2C, 1'b0, 4, 8'h0F, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
